// File: rtl/cpu15_pkg.sv
// Shared constants and FSM state encoding for the cpu15 operand-read stage.
package cpu15_pkg;

  localparam int NREG       = 8;
  localparam int DATA_W_DEF = 16;
  localparam int NREG_W_DEF = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD1 = 2'd1,
    HOLD2 = 2'd2
  } rd_state_t;

endpackage

// File: rtl/reg_mux8.sv
// 8:1 register selector, purely combinational; no flow control.
module reg_mux8
  import cpu15_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG_W = NREG_W_DEF
) (
  input  logic [NREG-1:0][DATA_W-1:0] i_regs,
  input  logic [NREG_W-1:0]           i_sel,
  output logic [DATA_W-1:0]           o_dat
);

  assign o_dat = i_regs[i_sel];

endmodule

// File: rtl/reg_rd.sv
// Operand read stage: one-cycle latency into a 2-entry skid (output + skid register);
// IN_READY is registered and drops only while both entries are held. Option: REG_RD_BYPASS_EN.
module reg_rd
  import cpu15_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG_W = NREG_W_DEF
) (
  input  logic              CLK_RD,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] REG_0,
  input  logic [DATA_W-1:0] REG_1,
  input  logic [DATA_W-1:0] REG_2,
  input  logic [DATA_W-1:0] REG_3,
  input  logic [DATA_W-1:0] REG_4,
  input  logic [DATA_W-1:0] REG_5,
  input  logic [DATA_W-1:0] REG_6,
  input  logic [DATA_W-1:0] REG_7,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [NREG_W-1:0] N_REG_A,
  input  logic [NREG_W-1:0] N_REG_B,
  input  logic [NREG_W-1:0] WB_N_REG,
  input  logic [DATA_W-1:0] WB_DATA,
  input  logic              WB_WEN,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OP_A,
  output logic [DATA_W-1:0] OP_B,
  output logic [7:0]        RD_CNT
);

  logic [NREG-1:0][DATA_W-1:0] w_regs;
  logic [DATA_W-1:0]           w_mux_a;
  logic [DATA_W-1:0]           w_mux_b;
  logic [DATA_W-1:0]           w_op_a;
  logic [DATA_W-1:0]           w_op_b;
  logic                        w_acc;

  rd_state_t         r_state;
  logic              r_in_rdy;
  logic              r_out_vld;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [DATA_W-1:0] r_skid_a;
  logic [DATA_W-1:0] r_skid_b;
  logic [7:0]        r_cnt;

  assign w_regs = {REG_7, REG_6, REG_5, REG_4, REG_3, REG_2, REG_1, REG_0};

  reg_mux8 #(.DATA_W(DATA_W), .NREG_W(NREG_W)) u_mux_a (
    .i_regs (w_regs),
    .i_sel  (N_REG_A),
    .o_dat  (w_mux_a)
  );

  reg_mux8 #(.DATA_W(DATA_W), .NREG_W(NREG_W)) u_mux_b (
    .i_regs (w_regs),
    .i_sel  (N_REG_B),
    .o_dat  (w_mux_b)
  );

`ifdef REG_RD_BYPASS_EN
  // A writeback landing on the capture edge wins over the stale register-file value.
  assign w_op_a = (WB_WEN && (WB_N_REG == N_REG_A)) ? WB_DATA : w_mux_a;
  assign w_op_b = (WB_WEN && (WB_N_REG == N_REG_B)) ? WB_DATA : w_mux_b;
`else
  logic w_unused;
  assign w_unused = &{1'b0, WB_N_REG, WB_DATA, WB_WEN};
  assign w_op_a   = w_mux_a;
  assign w_op_b   = w_mux_b;
`endif

  // r_in_rdy is low in HOLD2, so no accept can occur there.
  assign w_acc = IN_VALID && r_in_rdy;

  always_ff @(posedge CLK_RD) begin
    if (!RESET_N) begin
      r_state   <= EMPTY;
      r_in_rdy  <= 1'b0;
      r_out_vld <= 1'b0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_skid_a  <= '0;
      r_skid_b  <= '0;
      r_cnt     <= '0;
    end else begin
      r_in_rdy <= 1'b1;
      if (w_acc) r_cnt <= r_cnt + 8'd1;
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            r_op_a    <= w_op_a;
            r_op_b    <= w_op_b;
            r_out_vld <= 1'b1;
            r_state   <= HOLD1;
          end
        end
        HOLD1: begin
          if (w_acc && OUT_READY) begin
            r_op_a <= w_op_a;
            r_op_b <= w_op_b;
          end else if (w_acc) begin
            r_skid_a <= w_op_a;
            r_skid_b <= w_op_b;
            r_in_rdy <= 1'b0;
            r_state  <= HOLD2;
          end else if (OUT_READY) begin
            r_out_vld <= 1'b0;
            r_state   <= EMPTY;
          end
        end
        HOLD2: begin
          if (OUT_READY) begin
            r_op_a  <= r_skid_a;
            r_op_b  <= r_skid_b;
            r_state <= HOLD1;
          end else begin
            r_in_rdy <= 1'b0;
          end
        end
        default: begin
          r_out_vld <= 1'b0;
          r_state   <= EMPTY;
        end
      endcase
    end
  end

  assign IN_READY  = r_in_rdy;
  assign OUT_VALID = r_out_vld;
  assign OP_A      = r_op_a;
  assign OP_B      = r_op_b;
  assign RD_CNT    = r_cnt;

endmodule

// File: doc/reg_rd.md
REG_RD -- requirements
Module: reg_rd

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, register data width.
REQ-002 The block SHALL have parameter NREG_W, default 3, register-number width (8 registers).
REQ-003 The block SHALL have port CLK_RD, input, 1, stage clock; the only clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET_N, input, 1, synchronous active-low reset sampled on the CLK_RD rising edge.
REQ-005 The block SHALL have ports REG_0..REG_7, input, DATA_W each, register-file contents from the writeback stage.
REQ-006 The block SHALL have port IN_VALID, input, 1, upstream read request valid.
REQ-007 The block SHALL have port IN_READY, output, 1, block can accept a request.
REQ-008 The block SHALL have ports N_REG_A and N_REG_B, input, NREG_W each, source register numbers.
REQ-009 The block SHALL have ports WB_N_REG (input, NREG_W), WB_DATA (input, DATA_W) and WB_WEN (input, 1), the same-cycle writeback port.
REQ-010 The block SHALL have port OUT_VALID, output, 1, operands valid downstream.
REQ-011 The block SHALL have port OUT_READY, input, 1, downstream accepts operands.
REQ-012 The block SHALL have ports OP_A and OP_B, output, DATA_W each, fetched operands.
REQ-013 The block SHALL have port RD_CNT, output, 8, count of accepted requests.

Function
REQ-014 A request SHALL be accepted on a rising edge where IN_VALID=1 and IN_READY=1.
REQ-015 On accept, the block SHALL capture OP_A=REG_[N_REG_A] and OP_B=REG_[N_REG_B], both taken from the same edge.
REQ-016 Latency SHALL be one cycle: OUT_VALID=1 in the cycle after the accept when the output stage was empty or draining.
REQ-017 Buffering SHALL be a 2-entry skid (output register plus skid register) controlled by an FSM with states EMPTY, HOLD1 and HOLD2.
REQ-018 In EMPTY, an accept SHALL move the FSM to HOLD1.
REQ-019 In HOLD1, an accept with OUT_READY=0 SHALL store the new entry in the skid register and move the FSM to HOLD2.
REQ-020 In HOLD1, an accept with OUT_READY=1 SHALL replace the output register and keep the FSM in HOLD1.
REQ-021 In HOLD1, OUT_READY=1 with no accept SHALL move the FSM to EMPTY.
REQ-022 In HOLD2, OUT_READY=1 SHALL move the skid entry to the output register and move the FSM to HOLD1; no accept is possible in HOLD2.
REQ-023 IN_READY SHALL be registered: 0 in HOLD2, otherwise 1.
REQ-024 OUT_VALID SHALL be 1 in HOLD1 and HOLD2.
REQ-025 OP_A and OP_B SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-026 Operand selection SHALL be resolved at capture only; entries held in the skid register are not refreshed by later writebacks, and upstream control owns that hazard.
REQ-027 N_REG_A=N_REG_B SHALL be legal and SHALL yield identical operands.
REQ-028 RD_CNT SHALL increment by 1 per accept and wrap from 255 to 0.

Reset
REQ-029 With RESET_N=0 at an edge, the FSM SHALL go to EMPTY and both buffered entries SHALL be discarded, including mid-operation.
REQ-030 With RESET_N=0 at an edge, OUT_VALID, OP_A, OP_B and RD_CNT SHALL become 0.
REQ-031 IN_READY SHALL be 0 while RESET_N=0 and SHALL be 1 from the first edge after release.
REQ-032 Any request presented during reset SHALL NOT be accepted.

Configuration
REQ-033 With macro REG_RD_BYPASS_EN defined, the block SHALL substitute WB_DATA for an operand on an accept edge where WB_WEN=1 and WB_N_REG equals that operand's register number.
REQ-034 Without REG_RD_BYPASS_EN, WB_N_REG, WB_DATA and WB_WEN SHALL be ignored and operands SHALL come only from REG_0..REG_7.

Structure
REQ-035 Shared package cpu15_pkg SHALL hold the register count (8), DATA_W and NREG_W defaults, and the FSM state enum (EMPTY, HOLD1, HOLD2).
REQ-036 Sub-module reg_mux8 (8:1 DATA_W selector) SHALL be instantiated twice, once per operand.

Verification
REQ-037 Reset then REG_3=beaf, N_REG_A=3, N_REG_B=0, IN_VALID=1 for one cycle, OUT_READY=1 -> next cycle OUT_VALID=1, OP_A=beaf, OP_B=REG_0, RD_CNT=1.
REQ-038 OUT_READY=0 and three back-to-back requests -> first two accepted, FSM in HOLD2, IN_READY=0; OUT_READY=1 -> entries delivered in order, IN_READY=1 one cycle later.
REQ-039 With REG_RD_BYPASS_EN, REG_5=0000, WB_WEN=1, WB_N_REG=5, WB_DATA=1234 on the accept edge of N_REG_A=5 -> OP_A=1234; without the macro -> OP_A=0000.
REQ-040 RESET_N=0 asserted while in HOLD2 -> next cycle OUT_VALID=0, RD_CNT=0, OP_A=0; IN_READY=1 one cycle after release.
REQ-041 Continuous accepts with OUT_READY=1 for 256 cycles -> RD_CNT wraps to 0 and OUT_VALID stays 1 throughout.
